// File: rtl/tc_deser_pkg.sv
// Shared types and helpers for the bit-serial two's-complement deserializer.
// Imported by the negation cell and the tc_deser top.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } tc_state_t;

    localparam int TC_W_DEFAULT = 8;

    function automatic int tc_cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/tc_deser_neg_cell.sv
// Serial two's-complement negation cell: bits pass unchanged up to and including
// the first 1, every later bit is inverted. `seen_one` reports the flag in effect for this bit.
module tc_neg_cell
    import tc_pkg::*;
(
    input  logic clk,
    input  logic r_n,
    input  logic clr,
    input  logic en,
    input  logic sin,
    output logic out_bit,
    output logic seen_one
);

    logic seen_q;
    logic seen_d;

    // A clearing bit sees a fresh flag, so bit 0 of a frame always passes through.
    always_comb begin
        seen_one = clr ? 1'b0 : seen_q;
        out_bit  = sin ^ seen_one;
        seen_d   = seen_one | sin;
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            seen_q <= 1'b0;
        end else if (en) begin
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/tc_deser.sv
// Receives an LSB-first serial word, negates it on the fly and presents the
// W-bit result on a valid/ready output, with overflow and frame-abort flags.
module tc_deser
    import tc_pkg::*;
#(
    parameter int W = TC_W_DEFAULT
) (
    input  logic         clk,
    input  logic         r_n,
    input  logic         sin,
    input  logic         sin_vld,
    input  logic         sof,
    output logic         sin_rdy,
    output logic [W-1:0] dout,
    output logic         neg_ovf,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic         busy,
    output logic         frm_err
);

    localparam int CW = tc_cnt_w(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    tc_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    shiftReg_q;
    logic [W-1:0]    dout_q;
    logic            ovf_q;
    logic            doutVld_q;
    logic            busy_q;
    logic            frmErr_q;

    logic            accept;
    logic            startFrame;
    logic            cellEn;
    logic            outBit;
    logic            seenOne;
    logic [W-1:0]    shift_d;
    logic [W-1:0]    start_d;

    assign sin_rdy    = (state_q != HOLD) || dout_rdy;
    assign accept     = sin_vld && sin_rdy;
    assign startFrame = accept && sof;
    assign cellEn     = accept && (sof || (state_q == SHIFT));

    tc_neg_cell u_neg (
        .clk      (clk),
        .r_n      (r_n),
        .clr      (startFrame),
        .en       (cellEn),
        .sin      (sin),
        .out_bit  (outBit),
        .seen_one (seenOne)
    );

    // Right-shifting assembly: each new bit enters at the MSB, so bit 0 ends up as the LSB.
    always_comb begin
        shift_d = {outBit, shiftReg_q[W-1:1]};
        start_d = {outBit, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shiftReg_q <= '0;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
            doutVld_q  <= 1'b0;
            busy_q     <= 1'b0;
            frmErr_q   <= 1'b0;
        end else begin
            frmErr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (startFrame) begin
                        state_q    <= SHIFT;
                        cnt_q      <= CW'(1);
                        shiftReg_q <= start_d;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (startFrame) begin
                        // Early start-of-frame: drop the partial word and restart on this bit.
                        cnt_q      <= CW'(1);
                        shiftReg_q <= start_d;
                        frmErr_q   <= 1'b1;
                    end else if (accept) begin
                        shiftReg_q <= shift_d;
                        if (cnt_q == LAST_BIT) begin
                            state_q   <= HOLD;
                            cnt_q     <= '0;
                            dout_q    <= shift_d;
                            ovf_q     <= sin && !seenOne;
                            doutVld_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (dout_rdy) begin
                        doutVld_q <= 1'b0;
                        if (startFrame) begin
                            state_q    <= SHIFT;
                            cnt_q      <= CW'(1);
                            shiftReg_q <= start_d;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dout     = dout_q;
    assign neg_ovf  = ovf_q;
    assign dout_vld = doutVld_q;
    assign busy     = busy_q;
    assign frm_err  = frmErr_q;

endmodule

// File: tb/tb_tc_deser.sv
// Self-checking bench for tc_deser (W=8): directed scenarios plus randomized
// traffic checked against a word-level behavioural model.
module tb_tc_deser;

    localparam int W = 8;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         r_n;
    logic         sin;
    logic         sin_vld;
    logic         sof;
    logic         sin_rdy;
    logic [W-1:0] dout;
    logic         neg_ovf;
    logic         dout_vld;
    logic         dout_rdy;
    logic         busy;
    logic         frm_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a frame is a collected input value, the output its arithmetic negation.
    bit           mInFrame;
    bit           mHold;
    bit           mErr;
    bit           mOvf;
    int           mCnt;
    logic [W-1:0] mBits;
    logic [W-1:0] mWord;

    tc_deser #(.W(W)) dut (
        .clk      (clk),
        .r_n      (r_n),
        .sin      (sin),
        .sin_vld  (sin_vld),
        .sof      (sof),
        .sin_rdy  (sin_rdy),
        .dout     (dout),
        .neg_ovf  (neg_ovf),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .busy     (busy),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mInFrame = 1'b0;
        mHold    = 1'b0;
        mErr     = 1'b0;
        mOvf     = 1'b0;
        mCnt     = 0;
        mBits    = '0;
        mWord    = '0;
    endtask

    task automatic modelStep();
        bit rdy;
        bit acc;
        rdy  = !mHold || dout_rdy;
        acc  = sin_vld && rdy;
        mErr = 1'b0;
        if (mHold && dout_rdy) mHold = 1'b0;
        if (acc && sof) begin
            mErr     = mInFrame;
            mInFrame = 1'b1;
            mBits    = W'(sin);
            mCnt     = 1;
        end else if (acc && mInFrame) begin
            mBits[mCnt] = sin;
            mCnt++;
            if (mCnt == W) begin
                mInFrame = 1'b0;
                mHold    = 1'b1;
                mWord    = W'(0) - mBits;
                mOvf     = (mBits == MIN_NEG);
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("sin_rdy", 32'(sin_rdy), 32'(!mHold || dout_rdy));
        checkOutput("dout_vld", 32'(dout_vld), 32'(mHold));
        checkOutput("busy", 32'(busy), 32'(mInFrame));
        checkOutput("frm_err", 32'(frm_err), 32'(mErr));
        if (mHold) begin
            checkOutput("dout", 32'(dout), 32'(mWord));
            checkOutput("neg_ovf", 32'(neg_ovf), 32'(mOvf));
        end
    endtask

    // Drive one cycle of inputs at a falling edge, advance, and check at the next falling edge.
    task automatic applyStimulus(input logic v, input logic b, input logic s, input logic r);
        sin_vld  = v;
        sin      = b;
        sof      = s;
        dout_rdy = r;
        modelStep();
        @(negedge clk);
        checkModel();
    endtask

    task automatic sendFrame(input logic [W-1:0] value, input logic rdy);
        for (int i = 0; i < W; i++) applyStimulus(1'b1, value[i], i == 0, rdy);
    endtask

    task automatic sendFrameGap(input logic [W-1:0] value, input int gapAt, input int gapLen);
        for (int i = 0; i < W; i++) begin
            if (i == gapAt) begin
                for (int g = 0; g < gapLen; g++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            end
            applyStimulus(1'b1, value[i], i == 0, 1'b0);
        end
    endtask

    task automatic expectWord(input string tag, input logic [W-1:0] word, input logic ovf);
        checkOutput({tag, "_vld"}, 32'(dout_vld), 32'd1);
        checkOutput({tag, "_dout"}, 32'(dout), 32'(word));
        checkOutput({tag, "_ovf"}, 32'(neg_ovf), 32'(ovf));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(neg_ovf), 32'd0);
        checkOutput({tag, "_vld"}, 32'(dout_vld), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ferr"}, 32'(frm_err), 32'd0);
        checkOutput({tag, "_rdy"}, 32'(sin_rdy), 32'd1);
    endtask

    task automatic pulseReset(input string tag);
        #2 r_n = 1'b0;
        #1 checkResetOutputs(tag);
        modelReset();
        @(negedge clk);
        r_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] word;
        r_n      = 1'b0;
        sin      = 1'b0;
        sin_vld  = 1'b0;
        sof      = 1'b0;
        dout_rdy = 1'b0;
        modelReset();
        #12 checkResetOutputs("reset");
        @(negedge clk);
        r_n = 1'b1;

        sendFrame(8'h05, 1'b0);
        expectWord("f05", 8'hFB, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        sendFrameGap(8'h05, 4, 3);
        expectWord("f05gap", 8'hFB, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        sendFrame(8'h00, 1'b0);
        expectWord("f00", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        sendFrame(8'h80, 1'b0);
        expectWord("f80", 8'h80, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        sendFrame(8'h7F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput("stall_rdy", 32'(sin_rdy), 32'd0);
            expectWord("stall", 8'h81, 1'b0);
        end
        sendFrame(8'h01, 1'b1);
        expectWord("f01", 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        word = 8'h02;
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b1, word[i], i == 0, 1'b0);
            checkOutput("abort_ferr", 32'(frm_err), (i == 0) ? 32'd1 : 32'd0);
        end
        expectWord("f02", 8'hFE, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, i == 0, 1'b0);
        pulseReset("rst_mid");
        sendFrame(8'h33, 1'b0);
        pulseReset("rst_hold");
        sendFrame(8'h10, 1'b0);
        expectWord("f10", 8'hF0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            checkOutput("nosof_vld", 32'(dout_vld), 32'd0);
            checkOutput("nosof_busy", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic s;
            v = ($urandom % 4) != 0;
            s = mInFrame ? (($urandom % 20) == 0) : (($urandom % 3) == 0);
            applyStimulus(v, 1'($urandom), s, ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
